// File: rtl/memory_stage.sv
// Memory-access stage: issues loads/stores on a req/gnt/rvalid port and formats load data into MD.
// Latency is 1 cycle for non-memory ops and gnt/rvalid bound for memory ops; ED is stalled until the access completes and writeback can accept it.
module memory_stage #(
  parameter int XLEN        = 32,
  parameter int PC_WIDTH    = 32,
  parameter int INSTR_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0]    NOP_PC     = '0,
  parameter logic [INSTR_WIDTH-1:0] NOP_INSTR  = INSTR_WIDTH'(32'h0000_0013),
  parameter logic                   NOP_COMMIT = 1'b0
) (
  input  logic                   clk_i,
  input  logic                   rst,
  input  logic                   execute_vaild_i,
  input  logic [4:0]             ED_load_op_i,
  input  logic [2:0]             ED_store_op_i,
  input  logic                   ED_sel_reg_i,
  input  logic [XLEN-1:0]        ED_valE_i,
  input  logic [XLEN-1:0]        ED_rs2_data_i,
  input  logic                   ED_need_dstE_i,
  input  logic [4:0]             ED_dstE_i,
  input  logic [PC_WIDTH-1:0]    ED_PC_i,
  input  logic [INSTR_WIDTH-1:0] ED_instr_i,
  input  logic                   ED_commit_i,
  input  logic                   writeback_allow_in_i,
  output logic                   dmem_req_o,
  output logic                   dmem_we_o,
  output logic [XLEN-1:0]        dmem_addr_o,
  output logic [XLEN-1:0]        dmem_wdata_o,
  output logic [3:0]             dmem_be_o,
  input  logic                   dmem_gnt_i,
  input  logic                   dmem_rvalid_i,
  input  logic [XLEN-1:0]        dmem_rdata_i,
  output logic                   memory_allow_in_o,
  output logic                   memory_busy_o,
  output logic                   memory_vaild_o,
  output logic [XLEN-1:0]        MD_valW_o,
  output logic                   MD_need_dstE_o,
  output logic [4:0]             MD_dstE_o,
  output logic [PC_WIDTH-1:0]    MD_PC_o,
  output logic [INSTR_WIDTH-1:0] MD_instr_o,
  output logic                   MD_commit_o
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT_GNT, S_WAIT_RV, S_HOLD} state_t;

  state_t           state_q, state_d;
  logic             is_load, is_store, mem_op, load_vld, done;
  logic [XLEN-1:0]  hold_q, load_raw, load_shifted, load_fmt, valw;
  logic [4:0]       shamt;

  assign is_load  = |ED_load_op_i;
  assign is_store = |ED_store_op_i;
  assign mem_op   = execute_vaild_i & (is_load | is_store);
  assign load_vld = execute_vaild_i & is_load;

  assign dmem_req_o  = mem_op & ((state_q == S_IDLE) | (state_q == S_WAIT_GNT));
  assign dmem_we_o   = is_store;
  assign dmem_addr_o = {ED_valE_i[XLEN-1:2], 2'b00};

  always_comb begin
    dmem_be_o    = 4'b0000;
    dmem_wdata_o = ED_rs2_data_i;
    if (ED_store_op_i[0]) begin
      dmem_be_o    = 4'b0001 << ED_valE_i[1:0];
      dmem_wdata_o = {4{ED_rs2_data_i[7:0]}};
    end else if (ED_store_op_i[1]) begin
      dmem_be_o    = 4'b0011 << {ED_valE_i[1], 1'b0};
      dmem_wdata_o = {2{ED_rs2_data_i[15:0]}};
    end else if (ED_store_op_i[2] | is_load) begin
      dmem_be_o    = 4'b1111;
    end
  end

  always_comb begin
    state_d       = state_q;
    done          = 1'b0;
    memory_busy_o = 1'b0;
    case (state_q)
      S_IDLE, S_WAIT_GNT: begin
        done = execute_vaild_i & ~(is_load | is_store);
        if (dmem_req_o) begin
          memory_busy_o = load_vld;
          if (!dmem_gnt_i) begin
            state_d = S_WAIT_GNT;
          end else if (is_load) begin
            state_d = S_WAIT_RV;
          end else begin
            done    = 1'b1;
            state_d = writeback_allow_in_i ? S_IDLE : S_HOLD;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT_RV: begin
        memory_busy_o = load_vld;
        if (dmem_rvalid_i) begin
          done    = 1'b1;
          state_d = writeback_allow_in_i ? S_IDLE : S_HOLD;
        end
      end
      S_HOLD: begin
        done = 1'b1;
        if (writeback_allow_in_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign memory_allow_in_o = ~execute_vaild_i | (done & writeback_allow_in_i);

  // Once parked in HOLD the memory bus may carry anything, so use the captured word.
  always_comb begin
    load_raw = (state_q == S_HOLD) ? hold_q : dmem_rdata_i;
    if (ED_load_op_i[3] | ED_load_op_i[4]) shamt = {ED_valE_i[1], 4'b0000};
    else if (ED_load_op_i[2])              shamt = 5'd0;
    else                                   shamt = {ED_valE_i[1:0], 3'b000};
    load_shifted = load_raw >> shamt;
    load_fmt     = load_shifted;
    if (ED_load_op_i[0])      load_fmt = {{(XLEN-8){load_shifted[7]}}, load_shifted[7:0]};
    else if (ED_load_op_i[1]) load_fmt = {{(XLEN-16){load_shifted[15]}}, load_shifted[15:0]};
    else if (ED_load_op_i[3]) load_fmt = {{(XLEN-8){1'b0}}, load_shifted[7:0]};
    else if (ED_load_op_i[4]) load_fmt = {{(XLEN-16){1'b0}}, load_shifted[15:0]};
    valw = ED_sel_reg_i ? load_fmt : ED_valE_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk_i) begin
    if (rst) begin
      hold_q         <= '0;
      memory_vaild_o <= 1'b0;
      MD_valW_o      <= '0;
      MD_need_dstE_o <= 1'b0;
      MD_dstE_o      <= '0;
      MD_PC_o        <= NOP_PC;
      MD_instr_o     <= NOP_INSTR;
      MD_commit_o    <= NOP_COMMIT;
    end else begin
      if ((state_q == S_WAIT_RV) && dmem_rvalid_i) hold_q <= dmem_rdata_i;
      if (memory_allow_in_o && execute_vaild_i) begin
        memory_vaild_o <= 1'b1;
        MD_valW_o      <= valw;
        MD_need_dstE_o <= ED_need_dstE_i;
        MD_dstE_o      <= ED_dstE_i;
        MD_PC_o        <= ED_PC_i;
        MD_instr_o     <= ED_instr_i;
        MD_commit_o    <= ED_commit_i;
      end else if (writeback_allow_in_i) begin
        memory_vaild_o <= 1'b0;
        MD_valW_o      <= '0;
        MD_need_dstE_o <= 1'b0;
        MD_dstE_o      <= '0;
        MD_PC_o        <= NOP_PC;
        MD_instr_o     <= NOP_INSTR;
        MD_commit_o    <= NOP_COMMIT;
      end
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage: hand-computed vectors for ALU, lb, sh, lhu hold, reset mid-load, and sw/lw back-to-back.
module tb_memory_stage;
  logic        clk_i = 1'b0;
  logic        rst;
  logic        execute_vaild_i;
  logic [4:0]  ED_load_op_i;
  logic [2:0]  ED_store_op_i;
  logic        ED_sel_reg_i;
  logic [31:0] ED_valE_i, ED_rs2_data_i;
  logic        ED_need_dstE_i;
  logic [4:0]  ED_dstE_i;
  logic [31:0] ED_PC_i, ED_instr_i;
  logic        ED_commit_i;
  logic        writeback_allow_in_i;
  logic        dmem_req_o, dmem_we_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o;
  logic [3:0]  dmem_be_o;
  logic        dmem_gnt_i, dmem_rvalid_i;
  logic [31:0] dmem_rdata_i;
  logic        memory_allow_in_o, memory_busy_o, memory_vaild_o;
  logic [31:0] MD_valW_o;
  logic        MD_need_dstE_o;
  logic [4:0]  MD_dstE_o;
  logic [31:0] MD_PC_o, MD_instr_o;
  logic        MD_commit_o;

  int n_vec = 0;
  int n_err = 0;
  int req_cnt;

  always #5 clk_i = ~clk_i;

  memory_stage #(
    .XLEN(32), .PC_WIDTH(32), .INSTR_WIDTH(32),
    .NOP_PC(32'h0), .NOP_INSTR(32'h0000_0013), .NOP_COMMIT(1'b0)
  ) dut (
    .clk_i(clk_i), .rst(rst),
    .execute_vaild_i(execute_vaild_i),
    .ED_load_op_i(ED_load_op_i), .ED_store_op_i(ED_store_op_i),
    .ED_sel_reg_i(ED_sel_reg_i), .ED_valE_i(ED_valE_i), .ED_rs2_data_i(ED_rs2_data_i),
    .ED_need_dstE_i(ED_need_dstE_i), .ED_dstE_i(ED_dstE_i),
    .ED_PC_i(ED_PC_i), .ED_instr_i(ED_instr_i), .ED_commit_i(ED_commit_i),
    .writeback_allow_in_i(writeback_allow_in_i),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
    .dmem_wdata_o(dmem_wdata_o), .dmem_be_o(dmem_be_o),
    .dmem_gnt_i(dmem_gnt_i), .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
    .memory_allow_in_o(memory_allow_in_o), .memory_busy_o(memory_busy_o),
    .memory_vaild_o(memory_vaild_o), .MD_valW_o(MD_valW_o),
    .MD_need_dstE_o(MD_need_dstE_o), .MD_dstE_o(MD_dstE_o),
    .MD_PC_o(MD_PC_o), .MD_instr_o(MD_instr_o), .MD_commit_o(MD_commit_o)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, act, exp);
    end
  endtask

  task automatic cyc;
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_ed;
    execute_vaild_i = 1'b0;
    ED_load_op_i    = '0;
    ED_store_op_i   = '0;
    ED_sel_reg_i    = 1'b0;
  endtask

  task automatic set_ed(input logic [4:0] ld, input logic [2:0] st, input logic sel,
                        input logic [31:0] vale, input logic [31:0] rs2, input logic [31:0] pc);
    execute_vaild_i = 1'b1;
    ED_load_op_i    = ld;
    ED_store_op_i   = st;
    ED_sel_reg_i    = sel;
    ED_valE_i       = vale;
    ED_rs2_data_i   = rs2;
    ED_need_dstE_i  = 1'b1;
    ED_dstE_i       = 5'd7;
    ED_PC_i         = pc;
    ED_instr_i      = 32'hA000_0000 | pc;
    ED_commit_i     = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    idle_ed();
    ED_valE_i = '0; ED_rs2_data_i = '0; ED_need_dstE_i = 1'b0; ED_dstE_i = '0;
    ED_PC_i = '0; ED_instr_i = '0; ED_commit_i = 1'b0;
    writeback_allow_in_i = 1'b1;
    dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = '0;
    cyc(); cyc();

    // reset state
    chk("rst_vld",   32'(memory_vaild_o), 32'h0);
    chk("rst_valW",  MD_valW_o, 32'h0);
    chk("rst_instr", MD_instr_o, 32'h0000_0013);
    chk("rst_pc",    MD_PC_o, 32'h0);
    chk("rst_req",   32'(dmem_req_o), 32'h0);
    chk("rst_allow", 32'(memory_allow_in_o), 32'h1);
    chk("rst_busy",  32'(memory_busy_o), 32'h0);
    rst = 1'b0;
    dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'hFFFF_FFFF;
    cyc();
    dmem_rvalid_i = 1'b0;
    chk("stray_rv_vld", 32'(memory_vaild_o), 32'h0);

    // ALU op
    set_ed(5'b0, 3'b0, 1'b0, 32'h1234, 32'h0, 32'h100);
    #1;
    chk("alu_req",   32'(dmem_req_o), 32'h0);
    chk("alu_allow", 32'(memory_allow_in_o), 32'h1);
    cyc();
    chk("alu_vld",    32'(memory_vaild_o), 32'h1);
    chk("alu_valW",   MD_valW_o, 32'h1234);
    chk("alu_pc",     MD_PC_o, 32'h100);
    chk("alu_dst",    32'(MD_dstE_o), 32'd7);
    chk("alu_need",   32'(MD_need_dstE_o), 32'h1);
    chk("alu_commit", 32'(MD_commit_o), 32'h1);
    idle_ed();
    cyc();
    chk("bubble_vld",  32'(memory_vaild_o), 32'h0);
    chk("bubble_valW", MD_valW_o, 32'h0);

    // lb at 0x1003, immediate gnt, rvalid two cycles later
    set_ed(5'b00001, 3'b0, 1'b1, 32'h1003, 32'h0, 32'h104);
    dmem_gnt_i = 1'b1;
    #1;
    chk("lb_req",   32'(dmem_req_o), 32'h1);
    chk("lb_addr",  dmem_addr_o, 32'h1000);
    chk("lb_we",    32'(dmem_we_o), 32'h0);
    chk("lb_allow", 32'(memory_allow_in_o), 32'h0);
    chk("lb_busy",  32'(memory_busy_o), 32'h1);
    cyc();
    dmem_gnt_i = 1'b0;
    #1;
    chk("lb_req_wait",   32'(dmem_req_o), 32'h0);
    chk("lb_allow_wait", 32'(memory_allow_in_o), 32'h0);
    chk("lb_vld_wait",   32'(memory_vaild_o), 32'h0);
    cyc();
    dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h80FF_0000;
    #1;
    chk("lb_allow_rv", 32'(memory_allow_in_o), 32'h1);
    chk("lb_busy_rv",  32'(memory_busy_o), 32'h1);
    cyc();
    dmem_rvalid_i = 1'b0;
    chk("lb_vld",  32'(memory_vaild_o), 32'h1);
    chk("lb_valW", MD_valW_o, 32'hFFFF_FF80);
    idle_ed();

    // sh at 0x2002 with gnt delayed 3 cycles
    set_ed(5'b0, 3'b010, 1'b0, 32'h2002, 32'hABCD_1234, 32'h108);
    req_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) dmem_gnt_i = 1'b1;
      #1;
      if (dmem_req_o) req_cnt++;
      if (i == 0) begin
        chk("sh_be",    32'(dmem_be_o), 32'hC);
        chk("sh_wdata", dmem_wdata_o, 32'h1234_1234);
        chk("sh_we",    32'(dmem_we_o), 32'h1);
        chk("sh_allow", 32'(memory_allow_in_o), 32'h0);
      end
      if (i == 3) chk("sh_allow_gnt", 32'(memory_allow_in_o), 32'h1);
      cyc();
    end
    dmem_gnt_i = 1'b0;
    chk("sh_req_cycles", 32'(req_cnt), 32'd4);
    chk("sh_vld",  32'(memory_vaild_o), 32'h1);
    chk("sh_valW", MD_valW_o, 32'h2002);
    idle_ed();
    cyc();

    // lhu completes while writeback stalls for 2 cycles
    set_ed(5'b10000, 3'b0, 1'b1, 32'h3002, 32'h0, 32'h10C);
    dmem_gnt_i = 1'b1;
    cyc();
    dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h8001_5555;
    writeback_allow_in_i = 1'b0;
    #1;
    chk("lhu_allow_rv", 32'(memory_allow_in_o), 32'h0);
    cyc();
    dmem_rvalid_i = 1'b0; dmem_rdata_i = 32'hDEAD_BEEF;
    #1;
    chk("lhu_req_hold",   32'(dmem_req_o), 32'h0);
    chk("lhu_allow_hold", 32'(memory_allow_in_o), 32'h0);
    cyc();
    chk("lhu_vld_hold", 32'(memory_vaild_o), 32'h0);
    writeback_allow_in_i = 1'b1;
    #1;
    chk("lhu_allow_ret", 32'(memory_allow_in_o), 32'h1);
    chk("lhu_req_ret",   32'(dmem_req_o), 32'h0);
    cyc();
    chk("lhu_vld",  32'(memory_vaild_o), 32'h1);
    chk("lhu_valW", MD_valW_o, 32'h0000_8001);
    idle_ed();

    // reset while waiting for read data; the late rvalid must be ignored
    set_ed(5'b00100, 3'b0, 1'b1, 32'h4000, 32'h0, 32'h110);
    dmem_gnt_i = 1'b1;
    cyc();
    dmem_gnt_i = 1'b0;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h1234_5678;
    #1;
    chk("rstrv_vld",   32'(memory_vaild_o), 32'h0);
    chk("rstrv_instr", MD_instr_o, 32'h0000_0013);
    chk("rstrv_valW",  MD_valW_o, 32'h0);
    chk("rstrv_req",   32'(dmem_req_o), 32'h1);
    chk("rstrv_allow", 32'(memory_allow_in_o), 32'h0);
    cyc();
    dmem_rvalid_i = 1'b0;
    chk("rstrv_ignored", 32'(memory_vaild_o), 32'h0);
    dmem_gnt_i = 1'b1;
    cyc();
    dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h1234_5678;
    cyc();
    dmem_rvalid_i = 1'b0;
    chk("lw_vld",  32'(memory_vaild_o), 32'h1);
    chk("lw_valW", MD_valW_o, 32'h1234_5678);
    idle_ed();

    // back-to-back sw then lw, zero-wait memory
    set_ed(5'b0, 3'b100, 1'b0, 32'h5000, 32'hCAFE_F00D, 32'h200);
    dmem_gnt_i = 1'b1;
    #1;
    chk("sw_req",   32'(dmem_req_o), 32'h1);
    chk("sw_be",    32'(dmem_be_o), 32'hF);
    chk("sw_wdata", dmem_wdata_o, 32'hCAFE_F00D);
    chk("sw_allow", 32'(memory_allow_in_o), 32'h1);
    cyc();
    chk("sw_vld", 32'(memory_vaild_o), 32'h1);
    chk("sw_pc",  MD_PC_o, 32'h200);
    set_ed(5'b00100, 3'b0, 1'b1, 32'h5004, 32'h0, 32'h204);
    #1;
    chk("lw2_req",  32'(dmem_req_o), 32'h1);
    chk("lw2_addr", dmem_addr_o, 32'h5004);
    chk("lw2_we",   32'(dmem_we_o), 32'h0);
    cyc();
    dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h0BAD_C0DE;
    chk("b2b_bubble", 32'(memory_vaild_o), 32'h0);
    cyc();
    dmem_rvalid_i = 1'b0;
    chk("lw2_vld",  32'(memory_vaild_o), 32'h1);
    chk("lw2_valW", MD_valW_o, 32'h0BAD_C0DE);
    chk("lw2_pc",   MD_PC_o, 32'h204);
    idle_ed();
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
